// File: rtl/confirm_input_conditioner.sv
// Confirm-button and switch front end for the bulls-and-cows game FSM.
// Synchronises all inputs, debounces the button and emits one validated guess per press.

module confirm_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clock,
    input  logic        CPU_RESETN,
    input  logic        btn_raw,
    input  logic [15:0] sw_raw,
    output logic        btn_level,
    output logic        confirm_pulse,
    output logic [15:0] guess_out,
    output logic        guess_valid,
    output logic        guess_error
);

    typedef enum logic [1:0] {
        WAIT_PRESS,
        EMIT,
        WAIT_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0]       btn_sync_q;
    logic [SYNC_STAGES-1:0][15:0] sw_sync_q;
    logic                         btn_sync;
    logic [15:0]                  sw_sync;
    logic [CNT_W-1:0]             db_cnt;
    logic                         db_level;
    state_t                       state;
    logic                         sw_distinct;

    // A legal guess has four pairwise-distinct hex digits.
    function automatic logic nibbles_distinct(input logic [15:0] w);
        return (w[3:0]   != w[7:4])   && (w[3:0]  != w[11:8])  &&
               (w[3:0]   != w[15:12]) && (w[7:4]  != w[11:8])  &&
               (w[7:4]   != w[15:12]) && (w[11:8] != w[15:12]);
    endfunction

    assign btn_sync    = btn_sync_q[SYNC_STAGES-1];
    assign sw_sync     = sw_sync_q[SYNC_STAGES-1];
    assign sw_distinct = nibbles_distinct(sw_sync);
    assign btn_level   = db_level;

    // NOTE: synchroniser flops are cleared too, so a button held through reset
    // must be re-synchronised and re-debounced before it can produce a pulse.
    always_ff @(posedge clock) begin
        if (!CPU_RESETN) begin
            btn_sync_q <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
            sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (!CPU_RESETN) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (btn_sync == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_MAX) begin
            db_level <= btn_sync;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // NOTE: outputs are assigned with <= alongside the state so the strobes are
    // registered and line up with the EMIT state; blocking here would race readers.
    always_ff @(posedge clock) begin
        if (!CPU_RESETN) begin
            state         <= WAIT_PRESS;
            confirm_pulse <= 1'b0;
            guess_valid   <= 1'b0;
            guess_error   <= 1'b0;
            guess_out     <= 16'h0000;
        end else begin
            confirm_pulse <= 1'b0;
            guess_valid   <= 1'b0;
            guess_error   <= 1'b0;
            case (state)
                WAIT_PRESS: begin
                    if (db_level) begin
                        state         <= EMIT;
                        confirm_pulse <= 1'b1;
                        guess_out     <= sw_sync;
                        guess_valid   <= sw_distinct;
                        guess_error   <= !sw_distinct;
                    end
                end
                EMIT: begin
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!db_level) begin
                        state <= WAIT_PRESS;
                    end
                end
                default: begin
                    state <= WAIT_PRESS;
                end
            endcase
        end
    end

endmodule
